seq_detector: RTL and testbench



---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_sat_cnt.sv | 23 ++
 rtl/seq_detector.sv | 102 ++++++++++
 tb/tb_seq_detector.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } seq_det_state_t;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;
  localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; sat is high while cnt sits at its maximum value.
module seq_det_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with overlap; optional match counter under SEQ_DETECTOR_COUNT_EN.
// Handshake: bit_in is taken on a rising edge where bit_valid is high; no back-pressure.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN,
  parameter int unsigned          CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             det
`ifdef SEQ_DETECTOR_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
`endif
);

  localparam int unsigned    FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0]  ARM  = FW'(PAT_LEN - 1);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detector: PAT_LEN out of range");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W out of range");
  end

  seq_det_state_t     state_q, state_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               accept;
  logic               match;

  // clear outranks bit_valid: a bit arriving with clear is dropped.
  assign accept = bit_valid && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
      det     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det     <= match;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (clear) begin
      state_d = S_EMPTY;
      hist_d  = '0;
      fill_d  = '0;
    end else if (accept) begin
      hist_d = {hist_q[PAT_LEN-2:0], bit_in};
      if (fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
      case (state_q)
        S_EMPTY: state_d = (ARM <= FW'(1)) ? S_ARMED : S_FILL;
        S_FILL:  if (fill_q + 1'b1 == ARM) state_d = S_ARMED;
        S_ARMED: state_d = S_ARMED;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // In S_ARMED the history already holds PAT_LEN-1 real bits, so the
  // incoming bit completes a full window.
  always_comb begin
    match = 1'b0;
    if (state_q == S_ARMED && accept &&
        {hist_q[PAT_LEN-2:0], bit_in} == PATTERN) begin
      match = 1'b1;
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  seq_det_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (match),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: four parameterisations share one input stream, checked against a window model.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clear = 1'b0;
  logic det0, det1, det2, det3;

  always #5 clk = ~clk;

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] cnt3;
  logic       sat0, sat1, sat2, sat3;
`endif

  seq_detector u_d0 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear), .det(det0)
`ifdef SEQ_DETECTOR_COUNT_EN
    , .match_cnt(cnt0), .cnt_sat(sat0)
`endif
  );

  seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear), .det(det1)
`ifdef SEQ_DETECTOR_COUNT_EN
    , .match_cnt(cnt1), .cnt_sat(sat1)
`endif
  );

  seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear), .det(det2)
`ifdef SEQ_DETECTOR_COUNT_EN
    , .match_cnt(cnt2), .cnt_sat(sat2)
`endif
  );

  seq_detector #(.PAT_LEN(2), .PATTERN(2'b01), .CNT_W(3)) u_d3 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear), .det(det3)
`ifdef SEQ_DETECTOR_COUNT_EN
    , .match_cnt(cnt3), .cnt_sat(sat3)
`endif
  );

  // Reference model: accepted bits since the last reset/clear, newest at the back.
  int          plen [4] = '{4, 4, 4, 2};
  logic [15:0] pat  [4] = '{16'hB, 16'h0, 16'hB, 16'h1};
  int          cmax [4] = '{255, 255, 3, 7};
  logic        bits_q[$];
  logic [3:0]  exp_q[$];
  int          exp_cnt[4];
  int          pulses[4];
  int          total = 0;
  int          bad = 0;

  function automatic bit win_match(input int i);
    if (bits_q.size() < plen[i]) return 1'b0;
    for (int k = 0; k < plen[i]; k++) begin
      if (bits_q[bits_q.size() - 1 - k] !== pat[i][k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic c, input logic r);
    logic [3:0] e;
    logic [3:0] got;
    rst = r; clear = c; bit_valid = v; bit_in = b;
    @(posedge clk);
    e = '0;
    if (r || c) begin
      bits_q.delete();
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end else if (v) begin
      bits_q.push_back(b);
      if (bits_q.size() > 16) void'(bits_q.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (win_match(i)) begin
          e[i] = 1'b1;
          if (exp_cnt[i] < cmax[i]) exp_cnt[i]++;
        end
      end
    end
    exp_q.push_back(e);
    #1;
    got = {det3, det2, det1, det0};
    check("det", 16'(got), 16'(exp_q.pop_front()));
    for (int i = 0; i < 4; i++) pulses[i] += int'(got[i]);
`ifdef SEQ_DETECTOR_COUNT_EN
    check("cnt0", 16'(cnt0), 16'(exp_cnt[0]));
    check("cnt1", 16'(cnt1), 16'(exp_cnt[1]));
    check("cnt2", 16'(cnt2), 16'(exp_cnt[2]));
    check("cnt3", 16'(cnt3), 16'(exp_cnt[3]));
    check("sat", 16'({sat3, sat2, sat1, sat0}),
          16'({exp_cnt[3] == cmax[3], exp_cnt[2] == cmax[2],
               exp_cnt[1] == cmax[1], exp_cnt[0] == cmax[0]}));
`endif
  endtask

  // Feed n bits (MSB first), each followed by gap idle cycles with random bit_in.
  task automatic feed(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic zero_pulses();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overlapping stream on consecutive cycles
    zero_pulses();
    feed(16'b1011011, 7, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("overlap_pulses", 16'(pulses[0]), 16'd2);

    // Same stream with 3-cycle gaps
    step(1'b0, 1'b0, 1'b0, 1'b1);
    zero_pulses();
    feed(16'b1011011, 7, 3);
    check("gap_pulses", 16'(pulses[0]), 16'd2);

    // Clear with a valid bit mid-pattern
    step(1'b0, 1'b0, 1'b0, 1'b1);
    zero_pulses();
    feed(16'b101, 3, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    feed(16'b011, 3, 0);
    check("clear_no_det", 16'(pulses[0]), 16'd0);
    feed(16'b1011, 4, 0);
    check("clear_then_det", 16'(pulses[0]), 16'd1);

    // All-zero pattern straight after reset
    step(1'b0, 1'b0, 1'b0, 1'b1);
    zero_pulses();
    feed(16'b000, 3, 0);
    check("zeros_early", 16'(pulses[1]), 16'd0);
    feed(16'b00000, 5, 0);
    check("zeros_late", 16'(pulses[1]), 16'd5);

    // Small counter saturates; det keeps pulsing
    step(1'b0, 1'b0, 1'b0, 1'b1);
    zero_pulses();
    for (int r = 0; r < 5; r++) feed(16'b1011, 4, 0);
    check("sat_pulses", 16'(pulses[2]), 16'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-pattern
    zero_pulses();
    feed(16'b101, 3, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1, 1, 0);
    check("rst_mid", 16'(pulses[0]), 16'd0);

    // Random stream with occasional clear and reset
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
